// File: rtl/nfp_mul_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nfp_mul_pipe: 3-stage parametrised floating-point multiplier with        |
// | valid/ready flow control, RNE/RTZ rounding and per-result flags.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nfp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enb,
  input  logic                     rnd_mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     nfp_in1,
  input  logic [EXP_W+MAN_W:0]     nfp_in2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     nfp_out,
  output logic [3:0]               flags
);
  localparam int c_w      = 1 + EXP_W + MAN_W;
  localparam int c_sig_w  = MAN_W + 1;
  localparam int c_prod_w = 2 * MAN_W + 2;
  localparam int c_e_w    = EXP_W + 2;
  localparam int c_lz_w   = $clog2(c_prod_w + 1);
  localparam int c_x_w    = c_e_w + c_lz_w + 1;
  localparam logic signed [c_e_w-1:0] c_bias    = c_e_w'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [c_x_w-1:0] c_exp_max = c_x_w'((1 << EXP_W) - 1);
  localparam logic signed [c_x_w-1:0] c_x_zero  = '0;
  localparam logic signed [c_x_w-1:0] c_x_one   = c_x_w'(1);

  logic adv;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;

  // stage 1: unpacked operands
  logic s1_valid_q, s1_valid_d, s1_rnd_q, s1_rnd_d;
  logic s1_sign_a_q, s1_sign_a_d, s1_sign_b_q, s1_sign_b_d;
  logic s1_nan_a_q, s1_nan_a_d, s1_nan_b_q, s1_nan_b_d;
  logic s1_inf_a_q, s1_inf_a_d, s1_inf_b_q, s1_inf_b_d;
  logic s1_zero_a_q, s1_zero_a_d, s1_zero_b_q, s1_zero_b_d;
  logic [c_sig_w-1:0] s1_sig_a_q, s1_sig_a_d, s1_sig_b_q, s1_sig_b_d;
  logic [EXP_W-1:0]   s1_exp_a_q, s1_exp_a_d, s1_exp_b_q, s1_exp_b_d;

  // stage 2: raw product plus pre-resolved special result
  logic s2_valid_q, s2_valid_d, s2_rnd_q, s2_rnd_d, s2_sign_q, s2_sign_d;
  logic s2_spc_q, s2_spc_d;
  logic [c_prod_w-1:0]     s2_prod_q, s2_prod_d;
  logic signed [c_e_w-1:0] s2_exp_q, s2_exp_d;
  logic [c_w-1:0]          s2_spc_res_q, s2_spc_res_d;
  logic [3:0]              s2_spc_flags_q, s2_spc_flags_d;
  logic                    nan_sign;
  logic [c_sig_w-1:0]      nan_sig;

  // stage 3: output register
  logic out_valid_q, out_valid_d;
  logic [c_w-1:0] nfp_out_q, nfp_out_d;
  logic [3:0]     flags_q, flags_d;

  logic [c_lz_w-1:0]       lz;
  logic [c_prod_w-1:0]     norm;
  logic [MAN_W-1:0]        man_t, man_fin;
  logic [MAN_W:0]          man_r;
  logic                    guard, sticky, inc, carry;
  logic signed [c_x_w-1:0] e_norm, e_fin;
  logic [c_w-1:0]          res;
  logic [3:0]              res_flags;

  assign adv       = enb & (~out_valid_q | out_ready);
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign nfp_out   = nfp_out_q;
  assign flags     = flags_q;

  assign a_exp = nfp_in1[c_w-2 -: EXP_W];
  assign b_exp = nfp_in2[c_w-2 -: EXP_W];
  assign a_man = nfp_in1[MAN_W-1:0];
  assign b_man = nfp_in2[MAN_W-1:0];

  always_comb begin
    s1_valid_d  = in_valid;
    s1_rnd_d    = rnd_mode;
    s1_sign_a_d = nfp_in1[c_w-1];
    s1_sign_b_d = nfp_in2[c_w-1];
    s1_sig_a_d  = {|a_exp, a_man};
    s1_sig_b_d  = {|b_exp, b_man};
    // subnormals carry an effective exponent of 1 with a cleared hidden bit
    s1_exp_a_d  = (|a_exp) ? a_exp : EXP_W'(1);
    s1_exp_b_d  = (|b_exp) ? b_exp : EXP_W'(1);
    s1_nan_a_d  = (&a_exp) & (|a_man);
    s1_nan_b_d  = (&b_exp) & (|b_man);
    s1_inf_a_d  = (&a_exp) & ~(|a_man);
    s1_inf_b_d  = (&b_exp) & ~(|b_man);
    s1_zero_a_d = ~(|a_exp) & ~(|a_man);
    s1_zero_b_d = ~(|b_exp) & ~(|b_man);
  end

  always_comb begin
    s2_valid_d     = s1_valid_q;
    s2_rnd_d       = s1_rnd_q;
    s2_sign_d      = s1_sign_a_q ^ s1_sign_b_q;
    s2_prod_d      = c_prod_w'(s1_sig_a_q) * c_prod_w'(s1_sig_b_q);
    s2_exp_d       = $signed({2'b00, s1_exp_a_q}) + $signed({2'b00, s1_exp_b_q}) - c_bias;
    nan_sign       = s1_nan_a_q ? s1_sign_a_q : s1_sign_b_q;
    nan_sig        = s1_nan_a_q ? s1_sig_a_q : s1_sig_b_q;
    s2_spc_d       = 1'b1;
    s2_spc_res_d   = '0;
    s2_spc_flags_d = '0;
    if (s1_nan_a_q | s1_nan_b_q) begin
      s2_spc_res_d   = {nan_sign, {EXP_W{1'b1}}, 1'b1, nan_sig[MAN_W-2:0]};
      s2_spc_flags_d = {~nan_sig[MAN_W-1], 3'b000};
    end else if ((s1_inf_a_q & s1_zero_b_q) | (s1_inf_b_q & s1_zero_a_q)) begin
      s2_spc_res_d   = {s2_sign_d, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      s2_spc_flags_d = 4'b1000;
    end else if (s1_inf_a_q | s1_inf_b_q) begin
      s2_spc_res_d   = {s2_sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_zero_a_q | s1_zero_b_q) begin
      s2_spc_res_d   = {s2_sign_d, {(c_w-1){1'b0}}};
    end else begin
      s2_spc_d       = 1'b0;
    end
  end

  always_comb begin
    // normalise so the leading one lands in the product MSB
    lz = '0;
    for (int i = 0; i < c_prod_w; i++) begin
      if (s2_prod_q[i]) lz = c_lz_w'(c_prod_w - 1 - i);
    end
    norm    = s2_prod_q << lz;
    man_t   = norm[c_prod_w-2 -: MAN_W];
    guard   = norm[MAN_W];
    sticky  = |norm[MAN_W-1:0];
    inc     = ~s2_rnd_q & guard & (sticky | man_t[0]);
    man_r   = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};
    carry   = man_r[MAN_W];
    man_fin = carry ? '0 : man_r[MAN_W-1:0];
    e_norm  = c_x_w'(s2_exp_q) + c_x_one - $signed({{(c_x_w-c_lz_w){1'b0}}, lz});
    e_fin   = e_norm + $signed({{(c_x_w-1){1'b0}}, carry});
    if (s2_spc_q) begin
      res       = s2_spc_res_q;
      res_flags = s2_spc_flags_q;
    end else if (e_fin >= c_exp_max) begin
      res       = s2_rnd_q ? {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                           : {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flags = 4'b0101;
    end else if ((e_fin <= c_x_zero) | ~norm[c_prod_w-1]) begin
      res       = {s2_sign_q, {(c_w-1){1'b0}}};
      res_flags = 4'b0011;
    end else begin
      res       = {s2_sign_q, e_fin[EXP_W-1:0], man_fin};
      res_flags = {3'b000, guard | sticky};
    end
    out_valid_d = s2_valid_q;
    nfp_out_d   = s2_valid_q ? res : '0;
    flags_d     = s2_valid_q ? res_flags : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      nfp_out_q   <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      nfp_out_q   <= nfp_out_d;
      flags_q     <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_rnd_q       <= s1_rnd_d;
      s1_sign_a_q    <= s1_sign_a_d;
      s1_sign_b_q    <= s1_sign_b_d;
      s1_nan_a_q     <= s1_nan_a_d;
      s1_nan_b_q     <= s1_nan_b_d;
      s1_inf_a_q     <= s1_inf_a_d;
      s1_inf_b_q     <= s1_inf_b_d;
      s1_zero_a_q    <= s1_zero_a_d;
      s1_zero_b_q    <= s1_zero_b_d;
      s1_sig_a_q     <= s1_sig_a_d;
      s1_sig_b_q     <= s1_sig_b_d;
      s1_exp_a_q     <= s1_exp_a_d;
      s1_exp_b_q     <= s1_exp_b_d;
      s2_rnd_q       <= s2_rnd_d;
      s2_sign_q      <= s2_sign_d;
      s2_spc_q       <= s2_spc_d;
      s2_prod_q      <= s2_prod_d;
      s2_exp_q       <= s2_exp_d;
      s2_spc_res_q   <= s2_spc_res_d;
      s2_spc_flags_q <= s2_spc_flags_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_nfp_mul_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nfp_mul_pipe: directed and randomized bench for nfp_mul_pipe (FP32).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_nfp_mul_pipe;
  logic        clk = 1'b0;
  logic        reset, enb, rnd_mode, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] nfp_in1, nfp_in2, nfp_out;
  logic [3:0]  flags;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  fl;
    int          tag;
  } exp_t;

  exp_t        exp_q[$];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          adv_cnt  = 0;
  int          rx_cnt   = 0;
  logic        accepted = 1'b0;
  logic        use_dir  = 1'b0;
  logic [31:0] dir_res  = '0;
  logic [3:0]  dir_fl   = '0;
  logic        frz_prev = 1'b0;
  logic        hold_v;
  logic [31:0] hold_out;
  logic [3:0]  hold_fl;
  logic [31:0] spc_tab [10] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                32'h7FC0_0000, 32'h7F80_0001, 32'hFFA0_0003, 32'h0000_0001,
                                32'h7F7F_FFFF, 32'h3F80_0000};
  logic [31:0] ops_a [8];
  logic [31:0] ops_b [8];

  always #5 clk = ~clk;

  nfp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .enb(enb), .rnd_mode(rnd_mode),
    .in_valid(in_valid), .in_ready(in_ready), .nfp_in1(nfp_in1), .nfp_in2(nfp_in2),
    .out_valid(out_valid), .out_ready(out_ready), .nfp_out(nfp_out), .flags(flags)
  );

  // Exact-integer reference: product as significand*2^k, then rounded by remainder.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic rm);
    logic sa, sb, s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, exact;
    int ea, eb, k, be, sh;
    logic [22:0] ma, mb;
    logic [31:0] n;
    longint unsigned sig_a, sig_b, p, m, rem, half;
    sa = a[31]; ea = int'(a[30:23]); ma = a[22:0];
    sb = b[31]; eb = int'(b[30:23]); mb = b[22:0];
    s = sa ^ sb;
    a_nan = (ea == 255) && (ma != 0); b_nan = (eb == 255) && (mb != 0);
    a_inf = (ea == 255) && (ma == 0); b_inf = (eb == 255) && (mb == 0);
    a_zero = (ea == 0) && (ma == 0);  b_zero = (eb == 0) && (mb == 0);
    if (a_nan || b_nan) begin
      n = a_nan ? a : b;
      return {!n[22], 3'b000, n | 32'h0040_0000};
    end
    if ((a_inf && b_zero) || (b_inf && a_zero)) return {4'b1000, s, 8'hFF, 23'h40_0000};
    if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {4'b0000, s, 31'h0};
    sig_a = {41'd0, ma}; sig_b = {41'd0, mb};
    if (ea != 0) sig_a = sig_a + 64'h80_0000; else ea = 1;
    if (eb != 0) sig_b = sig_b + 64'h80_0000; else eb = 1;
    p = sig_a * sig_b;
    k = 47;
    while (k > 0 && !p[k]) k--;
    be = k + ea + eb - 173;
    sh = k - 23;
    if (sh > 0) begin
      m = p >> sh;
      rem = p - (m << sh);
      half = 64'd1 << (sh - 1);
      exact = (rem == 0);
      if (!rm && (rem > half || (rem == half && m[0]))) m = m + 1;
      if (m == (64'd1 << 24)) begin m = m >> 1; be++; end
    end else begin
      m = p << (-sh);
      exact = 1'b1;
    end
    if (be >= 255) return rm ? {4'b0101, s, 8'hFE, 23'h7F_FFFF} : {4'b0101, s, 8'hFF, 23'h0};
    if (be <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, !exact, s, be[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 15);
    case (sel)
      0: r = spc_tab[$urandom_range(0, 9)];
      1: r[30:23] = 8'h00;
      2: ;
      3: r[30:23] = 8'($urandom_range(190, 254));
      4: r[30:23] = 8'($urandom_range(1, 60));
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // One cycle: inputs are already driven; evaluate handshakes, then cross the edge.
  task automatic tick();
    logic exp_rdy;
    exp_t e;
    #1;
    if (frz_prev) begin
      check("hold_valid", 64'(out_valid), 64'(hold_v));
      check("hold_out", 64'(nfp_out), 64'(hold_out));
      check("hold_flags", 64'(flags), 64'(hold_fl));
    end
    exp_rdy = enb & (~out_valid | out_ready);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (out_valid === 1'b0) check("flags_idle", 64'(flags), 64'h0);
    if (out_valid && out_ready && enb) begin
      rx_cnt++;
      if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'h0);
      else begin
        e = exp_q.pop_front();
        check("result", 64'(nfp_out), 64'(e.res));
        check("flags", 64'(flags), 64'(e.fl));
        check("latency", 64'(adv_cnt - e.tag), 64'd3);
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      if (use_dir) begin e.res = dir_res; e.fl = dir_fl; end
      else {e.fl, e.res} = ref_mul(nfp_in1, nfp_in2, rnd_mode);
      e.tag = adv_cnt;
      exp_q.push_back(e);
    end
    frz_prev = !reset && !exp_rdy;
    hold_v = out_valid; hold_out = nfp_out; hold_fl = flags;
    if (exp_rdy) adv_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1; enb = 1'b1; in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'h0);
  endtask

  task automatic send_dir(input logic [31:0] a, input logic [31:0] b, input logic rm,
                          input logic [31:0] r, input logic [3:0] f);
    int n;
    nfp_in1 = a; nfp_in2 = b; rnd_mode = rm; in_valid = 1'b1;
    use_dir = 1'b1; dir_res = r; dir_fl = f;
    accepted = 1'b0; n = 0;
    while (!accepted && n < 20) begin tick(); n++; end
    if (!accepted) check("send_timeout", 64'(in_ready), 64'h1);
    in_valid = 1'b0; use_dir = 1'b0;
    drain();
  endtask

  task automatic stream(input logic stall_by_enb);
    int sent, rx0;
    for (int i = 0; i < 8; i++) begin ops_a[i] = rnd_op(); ops_b[i] = rnd_op(); end
    sent = 0; rx0 = rx_cnt;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (sent == 8 && exp_q.size() == 0) break;
      in_valid = (sent < 8);
      if (sent < 8) begin nfp_in1 = ops_a[sent]; nfp_in2 = ops_b[sent]; rnd_mode = sent[0]; end
      if (stall_by_enb) begin out_ready = 1'b1; enb = !(cyc >= 3 && cyc <= 6); end
      else begin enb = 1'b1; out_ready = !(cyc >= 3 && cyc <= 6); end
      tick();
      if (accepted) sent++;
    end
    in_valid = 1'b0; enb = 1'b1; out_ready = 1'b1;
    check("stream_count", 64'(rx_cnt - rx0), 64'd8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, cyc;
    reset = 1'b1; enb = 1'b1; rnd_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    nfp_in1 = '0; nfp_in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'h0);
    check("reset_nfp_out", 64'(nfp_out), 64'h0);
    check("reset_flags", 64'(flags), 64'h0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1;

    send_dir(32'h4040_0000, 32'h4000_0000, 1'b0, 32'h40C0_0000, 4'b0000);
    send_dir(32'h3F80_0001, 32'h3FC0_0000, 1'b0, 32'h3FC0_0002, 4'b0001);
    send_dir(32'h3F80_0001, 32'h3FC0_0000, 1'b1, 32'h3FC0_0001, 4'b0001);
    send_dir(32'h7F00_0000, 32'h4000_0000, 1'b0, 32'h7F80_0000, 4'b0101);
    send_dir(32'h7F00_0000, 32'h4000_0000, 1'b1, 32'h7F7F_FFFF, 4'b0101);
    send_dir(32'h7F80_0000, 32'h0000_0000, 1'b0, 32'h7FC0_0000, 4'b1000);
    send_dir(32'h0000_0000, 32'hFF80_0000, 1'b0, 32'hFFC0_0000, 4'b1000);
    send_dir(32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0001, 4'b1000);
    send_dir(32'h3F80_0000, 32'h7FC0_0005, 1'b0, 32'h7FC0_0005, 4'b0000);
    send_dir(32'h0080_0000, 32'h3F00_0000, 1'b0, 32'h0000_0000, 4'b0011);
    send_dir(32'hFF80_0000, 32'h4000_0000, 1'b0, 32'hFF80_0000, 4'b0000);
    send_dir(32'h8000_0000, 32'h3F80_0000, 1'b0, 32'h8000_0000, 4'b0000);

    stream(1'b0);
    stream(1'b1);

    sent = 0; cyc = 0;
    while (sent < 300 && cyc < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      enb       = ($urandom_range(0, 19) < 17);
      if (accepted || cyc == 0) begin
        nfp_in1 = rnd_op(); nfp_in2 = rnd_op(); rnd_mode = $urandom_range(0, 1);
      end
      tick();
      if (accepted) sent++;
      cyc++;
    end
    if (sent < 300) check("random_send_budget", 64'(sent), 64'd300);
    drain();

    out_ready = 1'b0; enb = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nfp_in1 = rnd_op(); nfp_in2 = rnd_op();
      tick();
    end
    in_valid = 1'b0; reset = 1'b1;
    tick();
    check("midreset_out_valid", 64'(out_valid), 64'h0);
    check("midreset_flags", 64'(flags), 64'h0);
    exp_q.delete();
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("post_reset_idle", 64'(out_valid), 64'h0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
`default_nettype wire
